// File: rtl/fp_issue_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_seq_pkg
// Description : Shared types and constants for the FP issue sequencer:
//               FSM states, FPU operation encodings, funct7[6:2] op codes
//               and default FPU latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_t;

  // funct7[6:2] values selecting each arithmetic operation
  localparam logic [4:0] c_f7_add = 5'b00000;
  localparam logic [4:0] c_f7_sub = 5'b00001;
  localparam logic [4:0] c_f7_mul = 5'b00010;
  localparam logic [4:0] c_f7_div = 5'b00011;

  // Default FPU timing
  localparam int c_add_lat     = 3;
  localparam int c_mul_lat     = 4;
  localparam int c_div_timeout = 32;
  localparam int c_cnt_w       = 6;

endpackage
`default_nettype wire

// File: rtl/fp_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_seq_if
// Description : Decode-side qualifiers, FPU handshake and FP register-file
//               write port of the FP issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_seq_if;
  import fp_seq_pkg::*;

  logic       instr_valid;
  logic       FP;
  logic       FPlw;
  logic       FPsw;
  logic       FP16;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       fpu_done;

  logic       fpu_start;
  fpu_op_t    fpu_op;
  logic       fpu_half;
  logic       stall;
  logic       fp_we;
  logic [4:0] fp_wa;
  logic       busy;
  logic       illegal;
  logic       timeout;

  // Controller / FPU side
  modport master (
    output instr_valid, FP, FPlw, FPsw, FP16, funct7, rd, fpu_done,
    input  fpu_start, fpu_op, fpu_half, stall, fp_we, fp_wa, busy, illegal, timeout
  );

  // Sequencer side
  modport slave (
    input  instr_valid, FP, FPlw, FPsw, FP16, funct7, rd, fpu_done,
    output fpu_start, fpu_op, fpu_half, stall, fp_we, fp_wa, busy, illegal, timeout
  );

endinterface
`default_nettype wire

// File: rtl/fp_issue_sequencer_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : fp_op_decode
// Description : Combinational decode of funct7[6:2] into FPU op, legality,
//               variable-latency flag and fixed latency in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_op_decode
  import fp_seq_pkg::*;
#(
  parameter int CNT_W   = c_cnt_w,
  parameter int ADD_LAT = c_add_lat,
  parameter int MUL_LAT = c_mul_lat
) (
  input  logic [4:0]       i_code,
  output fpu_op_t          o_op,
  output logic             o_legal,
  output logic             o_is_var,
  output logic [CNT_W-1:0] o_lat
);

  // Map op code to operation; div has no fixed latency
  always_comb begin
    o_op     = OP_ADD;
    o_legal  = 1'b0;
    o_is_var = 1'b0;
    o_lat    = '0;
    case (i_code)
      c_f7_add: begin o_op = OP_ADD; o_legal = 1'b1; o_lat = CNT_W'(ADD_LAT); end
      c_f7_sub: begin o_op = OP_SUB; o_legal = 1'b1; o_lat = CNT_W'(ADD_LAT); end
      c_f7_mul: begin o_op = OP_MUL; o_legal = 1'b1; o_lat = CNT_W'(MUL_LAT); end
      c_f7_div: begin o_op = OP_DIV; o_legal = 1'b1; o_is_var = 1'b1; end
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fp_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_issue_sequencer
// Description : Launches one FP arithmetic op at a time on a multi-cycle FPU,
//               stalls the pipeline while it runs, then issues a single FP
//               register-file write. fdiv waits on fpu_done with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_issue_sequencer
  import fp_seq_pkg::*;
#(
  parameter int ADD_LAT     = c_add_lat,
  parameter int MUL_LAT     = c_mul_lat,
  parameter int DIV_TIMEOUT = c_div_timeout,
  parameter int CNT_W       = c_cnt_w
) (
  input  logic    clk,
  input  logic    reset_n,
  fp_seq_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  fpu_op_t          r_op;
  logic             r_half;
  logic [4:0]       r_rd;
  logic             r_is_var;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fpu_start;
  logic             r_illegal;
  logic             r_timeout;

  fpu_op_t          w_op;
  logic             w_legal;
  logic             w_is_var;
  logic [CNT_W-1:0] w_lat;
  logic             w_arith;
  logic             w_accept;
  logic             w_bad;
  logic             w_timeout;
  logic             w_unused;

  // Loads/stores and non-FP opcodes never enter the sequencer
  assign w_arith  = bus.instr_valid & bus.FP & ~bus.FPlw & ~bus.FPsw;
  assign w_accept = (r_state == IDLE) & w_arith & w_legal;
  assign w_bad    = (r_state == IDLE) & w_arith & ~w_legal;
  assign w_unused = ^bus.funct7[1:0];

  fp_op_decode #(
    .CNT_W   (CNT_W),
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT)
  ) u_decode (
    .i_code   (bus.funct7[6:2]),
    .o_op     (w_op),
    .o_legal  (w_legal),
    .o_is_var (w_is_var),
    .o_lat    (w_lat)
  );

  // Next state and timeout detection; fpu_done beats the timeout
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = EXEC;
      EXEC: begin
        if (r_is_var) begin
          if (bus.fpu_done) begin
            w_next = WB;
          end else if (r_cnt == CNT_W'(DIV_TIMEOUT - 1)) begin
            w_next    = IDLE;
            w_timeout = 1'b1;
          end
        end else if (r_cnt == '0) begin
          w_next = WB;
        end
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Latched op context, cycle counter and single-cycle pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= OP_ADD;
      r_half      <= 1'b0;
      r_rd        <= '0;
      r_is_var    <= 1'b0;
      r_cnt       <= '0;
      r_fpu_start <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_fpu_start <= w_accept;
      r_illegal   <= w_bad;
      r_timeout   <= w_timeout;
      if (w_accept) begin
        r_op     <= w_op;
        r_half   <= bus.FP16;
        r_rd     <= bus.rd;
        r_is_var <= w_is_var;
        r_cnt    <= w_is_var ? '0 : (w_lat - CNT_W'(1));
      end else if (r_state == EXEC) begin
        if (r_is_var)          r_cnt <= r_cnt + CNT_W'(1);
        else if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Stall is gated by reset so every output is quiet while reset is held
  assign bus.stall     = reset_n & (w_accept | (r_state == EXEC));
  assign bus.busy      = (r_state != IDLE);
  assign bus.fp_we     = (r_state == WB);
  assign bus.fp_wa     = r_rd;
  assign bus.fpu_start = r_fpu_start;
  assign bus.fpu_op    = r_op;
  assign bus.fpu_half  = r_half;
  assign bus.illegal   = r_illegal;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_issue_sequencer
// Description : Scoreboard bench for fp_issue_sequencer. The issuing task
//               predicts start/write/illegal/timeout events and stall/busy
//               windows from the instruction alone; a monitor on the falling
//               edge checks every output event against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_issue_sequencer;
  import fp_seq_pkg::*;

  localparam int ADD_LAT     = 3;
  localparam int MUL_LAT     = 4;
  localparam int DIV_TIMEOUT = 32;
  localparam int CNT_W       = 6;

  typedef struct {
    int cyc;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Event kinds: 0 start, 1 write, 2 illegal, 3 timeout
  ev_t   evq[4][$];
  string knm[4] = '{"start", "write", "illegal", "timeout"};
  int    st_lo = 1, st_hi = 0, bz_lo = 1, bz_hi = 0;

  fp_seq_if bus ();

  fp_issue_sequencer #(
    .ADD_LAT     (ADD_LAT),
    .MUL_LAT     (MUL_LAT),
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, int'(bus.stall), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_start"}, int'(bus.fpu_start), 0);
    chk({tag, "_we"}, int'(bus.fp_we), 0);
    chk({tag, "_wa"}, int'(bus.fp_wa), 0);
    chk({tag, "_op"}, int'(bus.fpu_op), 0);
    chk({tag, "_half"}, int'(bus.fpu_half), 0);
    chk({tag, "_illegal"}, int'(bus.illegal), 0);
    chk({tag, "_timeout"}, int'(bus.timeout), 0);
  endtask

  task automatic clear_inputs();
    bus.instr_valid = 1'b0;
    bus.FP          = 1'($urandom_range(0, 1));
    bus.FPlw        = 1'($urandom_range(0, 1));
    bus.FPsw        = 1'($urandom_range(0, 1));
    bus.FP16        = 1'($urandom_range(0, 1));
    bus.funct7      = 7'($urandom);
    bus.rd          = 5'($urandom);
    bus.fpu_done    = 1'b0;
  endtask

  // Present one instruction in the current (idle) cycle, predict its effects,
  // and keep it on the bus, as a stalled decode stage would, until idle again.
  // done_k: EXEC cycle (1-based) in which fpu_done arrives for fdiv, 0 = never.
  task automatic issue(input logic v, input logic fp, input logic lw, input logic sw,
                       input logic half, input logic [6:0] f7, input logic [4:0] rd,
                       input int done_k);
    int t, code, lat, n;
    bit arith;
    t     = cyc;
    code  = int'(f7[6:2]);
    arith = v && fp && !lw && !sw;
    bus.instr_valid = v;
    bus.FP   = fp;
    bus.FPlw = lw;
    bus.FPsw = sw;
    bus.FP16 = half;
    bus.funct7 = f7;
    bus.rd   = rd;
    bus.fpu_done = 1'b0;
    if (arith && code > 3) begin
      evq[2].push_back('{t + 1, 0});
    end else if (arith) begin
      evq[0].push_back('{t + 1, int'(half) * 4 + code});
      st_lo = t;
      bz_lo = t + 1;
      if (code < 3) begin
        lat = (code < 2) ? ADD_LAT : MUL_LAT;
        evq[1].push_back('{t + lat + 1, int'(rd)});
        st_hi = t + lat;
        bz_hi = t + lat + 1;
      end else if (done_k >= 1 && done_k <= DIV_TIMEOUT) begin
        evq[1].push_back('{t + done_k + 1, int'(rd)});
        st_hi = t + done_k;
        bz_hi = t + done_k + 1;
      end else begin
        evq[3].push_back('{t + DIV_TIMEOUT + 1, 0});
        st_hi = t + DIV_TIMEOUT;
        bz_hi = t + DIV_TIMEOUT;
      end
    end
    @(posedge clk); #1;
    if (arith && code <= 3) begin
      n = 0;
      while (bus.busy && n < 200) begin
        if (code == 3) bus.fpu_done = (done_k != 0) && (cyc == t + done_k);
        else           bus.fpu_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      chk("busy_bound", int'(bus.busy), 0);
    end
    clear_inputs();
  endtask

  // Monitor: stall/busy windows every cycle, and event pops on each output pulse
  always @(negedge clk) begin : mon
    logic flg[4];
    int   dat[4];
    ev_t  e;
    if (reset_n && mon_en) begin
      chk("stall", int'(bus.stall), int'(cyc >= st_lo && cyc <= st_hi));
      chk("busy", int'(bus.busy), int'(cyc >= bz_lo && cyc <= bz_hi));
      flg[0] = bus.fpu_start; dat[0] = int'(bus.fpu_half) * 4 + int'(bus.fpu_op);
      flg[1] = bus.fp_we;     dat[1] = int'(bus.fp_wa);
      flg[2] = bus.illegal;   dat[2] = 0;
      flg[3] = bus.timeout;   dat[3] = 0;
      for (int k = 0; k < 4; k++) begin
        if (evq[k].size() > 0 && evq[k][0].cyc < cyc) begin
          e = evq[k].pop_front();
          chk({knm[k], "_missing_at_cycle"}, cyc, e.cyc);
        end
        if (flg[k]) begin
          if (evq[k].size() == 0) begin
            chk({knm[k], "_unexpected"}, int'(flg[k]), 0);
          end else begin
            e = evq[k].pop_front();
            chk({knm[k], "_cycle"}, cyc, e.cyc);
            chk({knm[k], "_data"}, dat[k], e.data);
          end
        end
      end
    end
  end

  initial begin
    int ta, tb, kind, dk;
    clear_inputs();
    bus.FP = 1'b1; bus.instr_valid = 1'b1; bus.funct7 = 7'b0000000;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    clear_inputs();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed cases
    issue(1, 1, 0, 0, 0, 7'b0000000, 5'd5, 0);      // fadd rd=5
    issue(1, 1, 0, 0, 1, 7'b0001000, 5'd31, 0);     // fmul half rd=31
    issue(1, 1, 0, 0, 0, 7'b0001100, 5'd7, 3);      // fdiv done in 3rd EXEC cycle
    issue(1, 1, 0, 0, 1, 7'b0001101, 5'd12, 0);     // fdiv timeout
    issue(1, 1, 1, 0, 0, 7'b0000000, 5'd3, 0);      // flw
    issue(1, 1, 0, 1, 0, 7'b0001000, 5'd4, 0);      // fsw
    issue(1, 1, 0, 0, 0, 7'b1111100, 5'd6, 0);      // illegal funct7
    issue(1, 1, 0, 0, 0, 7'b0001100, 5'd8, 32);     // fdiv done in last allowed cycle

    // Reset in the second EXEC cycle of an fmul
    mon_en = 1'b0;
    bus.instr_valid = 1'b1; bus.FP = 1'b1; bus.FPlw = 1'b0; bus.FPsw = 1'b0;
    bus.FP16 = 1'b1; bus.funct7 = 7'b0001000; bus.rd = 5'd9;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(posedge clk); #1;
    chk_all_zero("held_reset");
    clear_inputs();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(1, 1, 0, 0, 0, 7'b0000010, 5'd17, 0);     // fadd after reset

    // Back-to-back fsub
    ta = cyc;
    issue(1, 1, 0, 0, 0, 7'b0000100, 5'd10, 0);
    tb = cyc;
    issue(1, 1, 0, 0, 1, 7'b0000111, 5'd11, 0);
    chk("b2b_issue_gap", tb - ta, ADD_LAT + 2);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      dk   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, DIV_TIMEOUT);
      case (kind)
        0: issue(1, 1, 1, 0, 1'($urandom), 7'($urandom), 5'($urandom), 0);
        1: issue(1, 1, 0, 1, 1'($urandom), 7'($urandom), 5'($urandom), 0);
        2: issue(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                 7'($urandom), 5'($urandom), 0);
        3: issue(1, 1, 0, 0, 1'($urandom), {5'($urandom_range(4, 31)), 2'($urandom)},
                 5'($urandom), 0);
        default: issue(1, 1, 0, 0, 1'($urandom), {5'($urandom_range(0, 3)), 2'($urandom)},
                       5'($urandom), dk);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk({knm[k], "_left_in_queue"}, evq[k].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_issue_sequencer.md
Name: fp_issue_sequencer

Overview:
- Multi-cycle issue/stall sequencer for the floating-point arithmetic path of the RISC-V core.
- Sits beside the main instruction controller and consumes its FP, FPlw, FPsw and FP16 qualifiers plus funct7 and rd.
- Launches one operation at a time on a multi-cycle FPU, freezes the pipeline while the FPU is busy, then issues one FP register-file write.
- FP loads and stores stay single-cycle and bypass this block.

Parameters:
ADD_LAT, 3, fixed FPU latency in cycles for fadd/fsub (≥1)
MUL_LAT, 4, fixed FPU latency in cycles for fmul (≥1)
DIV_TIMEOUT, 32, maximum EXEC cycles spent waiting for fpu_done on fdiv
CNT_W, 6, width of the internal cycle counter; must hold max(ADD_LAT, MUL_LAT, DIV_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
instr_valid  in  1  decoded instruction is valid this cycle
FP  in  1  FP-class opcode (arith, flw or fsw)
FPlw  in  1  flw opcode
FPsw  in  1  fsw opcode
FP16  in  1  half-precision arithmetic
funct7  in  7  op select; uses bits [6:2]
rd  in  5  destination FP register
fpu_done  in  1  FPU result valid; used for fdiv only
fpu_start  out  1  one-cycle launch pulse to the FPU
fpu_op  out  2  00 add, 01 sub, 10 mul, 11 div
fpu_half  out  1  latched FP16 qualifier
stall  out  1  holds PC and the decode stage
fp_we  out  1  FP register-file write enable
fp_wa  out  5  FP register-file write address
busy  out  1  state is not IDLE
illegal  out  1  one-cycle pulse for an unsupported funct7
timeout  out  1  one-cycle pulse when fdiv is abandoned

Behaviour:
- Reset state: while reset_n is low, state is IDLE and every output and latched register is 0. Reset has immediate effect at any point, including mid-operation. A pending op is dropped and never written back.
- Arithmetic request: arith = instr_valid & FP & ~FPlw & ~FPsw.
- Decode of funct7[6:2]:
  - 00000 → add, latency ADD_LAT
  - 00001 → sub, latency ADD_LAT
  - 00010 → mul, latency MUL_LAT
  - 00011 → div, variable latency
  - any other value → illegal
- IDLE, cycle T:
  - arith with a legal op: stall=1 combinationally in T. Latch op, FP16 and rd. Next state is EXEC.
  - arith with an illegal op: illegal=1 in T (registered, visible T+1 for one cycle). No stall, stay IDLE.
- EXEC entry: fpu_start=1 in the first EXEC cycle only, with fpu_op and fpu_half valid. The counter loads LAT-1 for fixed ops or 0 for div. stall=1 throughout EXEC.
- Fixed ops: the counter decrements each EXEC cycle. When the counter is 0, next state is WB. EXEC therefore lasts exactly LAT cycles. fpu_done is ignored.
- Div:
  - fpu_done may arrive in any EXEC cycle, including the start cycle; next state is WB.
  - The counter increments each cycle. If it reaches DIV_TIMEOUT-1 without fpu_done, timeout pulses for one cycle, the state returns to IDLE and there is no write.
  - If fpu_done and timeout coincide, done wins.
- WB (one cycle): fp_we=1, fp_wa=latched rd, stall=0 so the pipeline advances past the instruction. instr_valid is ignored in WB, so there is no re-issue. Next state is IDLE.
- Stall budget: a fixed op stalls for LAT+1 cycles (T through T+LAT) and writes at T+LAT+1.
- Outputs outside the relevant states: fp_we=0 and fpu_start=0 outside WB/EXEC-entry. fp_wa and fpu_op hold their latched values.
- Back-to-back FP ops: the second op is accepted in the IDLE cycle right after WB.

Decomposition:
- Package fp_seq_pkg: state enum (IDLE, EXEC, WB), 2-bit fpu_op encodings, funct7[6:2] op codes, and default latency constants.
- Sub-module fp_op_decode: combinational funct7[6:2] → {op, legal, is_var, lat}. It is instantiated once inside the sequencer.

Test Plan:
- fadd, FP16=0, rd=5, ADD_LAT=3, accepted at T → stall high T..T+3, fpu_start only at T+1 with fpu_op=00, fp_we=1 and fp_wa=5 at T+4, then IDLE at T+5.
- fmul with FP16=1, rd=31 → fpu_half=1, stall high for 5 cycles, write at T+5 with fp_wa=31.
- fdiv with fpu_done asserted at the third EXEC cycle → WB next cycle, single write. Separately, fdiv with no done → timeout pulse after 32 EXEC cycles, fp_we never asserted, busy=0 afterwards.
- flw, fsw and funct7=1111100 → no stall. flw/fsw produce no illegal; funct7=1111100 produces exactly one illegal pulse.
- reset_n low at the second EXEC cycle of fmul → all outputs 0 asynchronously. After release, a new fadd completes normally with no stray write.
- Two consecutive fsub instructions → second fpu_start exactly ADD_LAT+2 cycles after the first, two writes total.
